// File: rtl/ahb_arb_2m1s.sv
// Two-master, one-slave AHB-Lite arbiter. Uncontended transfers pass straight
// through. A losing address phase is parked in a per-master hold register and replayed as NONSEQ.
module ahb_arb_2m1s #(
  parameter int ARB_MODE = 0
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HADDR,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HRESP,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HADDR,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HRESP,
  output logic        S_HSEL,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [3:0]  S_HPROT,
  output logic        S_HMASTLOCK,
  output logic [31:0] S_HADDR,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WAIT = 2'd1,
    M_DATA = 2'd2
  } mst_state_e;

  // Master-side signals gathered into arrays indexed by master number
  logic [1:0]  m_htrans    [2];
  logic        m_hwrite    [2];
  logic [2:0]  m_hsize     [2];
  logic [2:0]  m_hburst    [2];
  logic [3:0]  m_hprot     [2];
  logic        m_hmastlock [2];
  logic [31:0] m_haddr     [2];
  logic [31:0] m_hwdata    [2];
  logic [31:0] m_hrdata    [2];
  logic [1:0]  m_hresp;
  logic [1:0]  m_hready;

  assign m_htrans[0]    = M0_HTRANS;
  assign m_hwrite[0]    = M0_HWRITE;
  assign m_hsize[0]     = M0_HSIZE;
  assign m_hburst[0]    = M0_HBURST;
  assign m_hprot[0]     = M0_HPROT;
  assign m_hmastlock[0] = M0_HMASTLOCK;
  assign m_haddr[0]     = M0_HADDR;
  assign m_hwdata[0]    = M0_HWDATA;
  assign m_htrans[1]    = M1_HTRANS;
  assign m_hwrite[1]    = M1_HWRITE;
  assign m_hsize[1]     = M1_HSIZE;
  assign m_hburst[1]    = M1_HBURST;
  assign m_hprot[1]     = M1_HPROT;
  assign m_hmastlock[1] = M1_HMASTLOCK;
  assign m_haddr[1]     = M1_HADDR;
  assign m_hwdata[1]    = M1_HWDATA;

  assign M0_HREADY = m_hready[0];
  assign M0_HRDATA = m_hrdata[0];
  assign M0_HRESP  = m_hresp[0];
  assign M1_HREADY = m_hready[1];
  assign M1_HRDATA = m_hrdata[1];
  assign M1_HRESP  = m_hresp[1];

  mst_state_e  state_q [2];
  mst_state_e  state_d [2];
  logic [1:0]  pend_q, pend_d;
  logic [31:0] hold_addr_q  [2];
  logic [31:0] hold_addr_d  [2];
  logic        hold_write_q [2];
  logic        hold_write_d [2];
  logic [2:0]  hold_size_q  [2];
  logic [2:0]  hold_size_d  [2];
  logic [2:0]  hold_burst_q [2];
  logic [2:0]  hold_burst_d [2];
  logic [3:0]  hold_prot_q  [2];
  logic [3:0]  hold_prot_d  [2];
  logic        hold_lock_q  [2];
  logic        hold_lock_d  [2];
  logic        data_valid_q, data_valid_d;
  logic        data_owner_q, data_owner_d;
  logic        last_grant_q, last_grant_d;
  logic        lock_q, lock_d;

  logic [1:0]  live_req;
  logic [1:0]  req;
  logic [1:0]  lock_eff;
  logic        win;
  logic        grant_valid;
  logic        commit;
  logic        sel_pend;

  // State register
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]      <= M_IDLE;
        hold_addr_q[i]  <= '0;
        hold_write_q[i] <= 1'b0;
        hold_size_q[i]  <= '0;
        hold_burst_q[i] <= '0;
        hold_prot_q[i]  <= '0;
        hold_lock_q[i]  <= 1'b0;
      end
      pend_q       <= '0;
      data_valid_q <= 1'b0;
      data_owner_q <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]      <= state_d[i];
        hold_addr_q[i]  <= hold_addr_d[i];
        hold_write_q[i] <= hold_write_d[i];
        hold_size_q[i]  <= hold_size_d[i];
        hold_burst_q[i] <= hold_burst_d[i];
        hold_prot_q[i]  <= hold_prot_d[i];
        hold_lock_q[i]  <= hold_lock_d[i];
      end
      pend_q       <= pend_d;
      data_valid_q <= data_valid_d;
      data_owner_q <= data_owner_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
    end
  end

  // Requests; live requests are masked while reset is asserted so the slave sees IDLE
  always_comb begin
    live_req = '0;
    req      = '0;
    lock_eff = '0;
    for (int i = 0; i < 2; i++) begin
      live_req[i] = m_hready[i] & m_htrans[i][1] & RES_N;
      req[i]      = pend_q[i] | live_req[i];
      lock_eff[i] = pend_q[i] ? hold_lock_q[i] : m_hmastlock[i];
    end
  end

  always_comb begin
    grant_valid = |req;
    if (lock_q && req[last_grant_q] && lock_eff[last_grant_q]) begin
      win = last_grant_q;
    end else if (ARB_MODE == 1) begin
      win = ~req[0];
    end else if (&req) begin
      win = ~last_grant_q;
    end else begin
      win = req[1];
    end
    commit = S_HREADYOUT & grant_valid;
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]      = state_q[i];
      hold_addr_d[i]  = hold_addr_q[i];
      hold_write_d[i] = hold_write_q[i];
      hold_size_d[i]  = hold_size_q[i];
      hold_burst_d[i] = hold_burst_q[i];
      hold_prot_d[i]  = hold_prot_q[i];
      hold_lock_d[i]  = hold_lock_q[i];
    end
    pend_d = pend_q;
    for (int i = 0; i < 2; i++) begin
      if (pend_q[i]) begin
        if (commit && (win == 1'(i))) begin
          state_d[i] = M_DATA;
          pend_d[i]  = 1'b0;
        end else begin
          state_d[i] = M_WAIT;
        end
      end else if (live_req[i]) begin
        if (commit && (win == 1'(i))) begin
          state_d[i] = M_DATA;
        end else begin
          state_d[i]      = M_WAIT;
          pend_d[i]       = 1'b1;
          hold_addr_d[i]  = m_haddr[i];
          hold_write_d[i] = m_hwrite[i];
          hold_size_d[i]  = m_hsize[i];
          hold_burst_d[i] = m_hburst[i];
          hold_prot_d[i]  = m_hprot[i];
          hold_lock_d[i]  = m_hmastlock[i];
        end
      end else if (state_q[i] == M_DATA && !S_HREADYOUT) begin
        state_d[i] = M_DATA;
      end else begin
        state_d[i] = M_IDLE;
      end
    end

    data_valid_d = data_valid_q;
    data_owner_d = data_owner_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    if (S_HREADYOUT) begin
      if (grant_valid) begin
        data_valid_d = 1'b1;
        data_owner_d = win;
        last_grant_d = win;
        lock_d       = lock_eff[win];
      end else begin
        data_valid_d = 1'b0;
        lock_d       = 1'b0;
      end
    end
  end

  // Output logic: per-master HREADY
  always_comb begin
    m_hready = '1;
    for (int i = 0; i < 2; i++) begin
      case (state_q[i])
        M_WAIT:  m_hready[i] = 1'b0;
        M_DATA:  m_hready[i] = S_HREADYOUT;
        default: m_hready[i] = 1'b1;
      endcase
    end
  end

  // Slave address-phase mux
  always_comb begin
    sel_pend    = pend_q[win];
    S_HADDR     = sel_pend ? hold_addr_q[win]  : m_haddr[win];
    S_HWRITE    = sel_pend ? hold_write_q[win] : m_hwrite[win];
    S_HSIZE     = sel_pend ? hold_size_q[win]  : m_hsize[win];
    S_HBURST    = sel_pend ? hold_burst_q[win] : m_hburst[win];
    S_HPROT     = sel_pend ? hold_prot_q[win]  : m_hprot[win];
    S_HMASTLOCK = sel_pend ? hold_lock_q[win]  : m_hmastlock[win];
    if (!grant_valid) begin
      S_HTRANS = HTRANS_IDLE;
    end else if (sel_pend) begin
      S_HTRANS = HTRANS_NONSEQ;
    end else begin
      S_HTRANS = m_htrans[win];
    end
  end

  assign S_HSEL   = S_HTRANS[1];
  assign S_HREADY = S_HREADYOUT;
  assign S_HWDATA = m_hwdata[data_owner_q];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic owns_data;
      assign owns_data    = data_valid_q & (data_owner_q == 1'(gi));
      assign m_hrdata[gi] = owns_data ? S_HRDATA : '0;
      assign m_hresp[gi]  = owns_data & S_HRESP;
    end
  endgenerate

endmodule

// File: tb/tb_ahb_arb_2m1s.sv
// Directed bench for ahb_arb_2m1s: round-robin instance on a memory slave with an
// error address, plus a fixed-priority instance on an always-ready slave.
module tb_ahb_arb_2m1s;

  logic        clk;
  logic        res_n;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [2:0]  m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hmastlock, m1_hmastlock;
  logic [31:0] m0_haddr, m1_haddr;
  logic [31:0] m0_hwdata, m1_hwdata;

  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        s_hsel, s_hwrite, s_hmastlock, s_hready;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hreadyout, s_hresp;

  logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp;
  logic [31:0] fp_m0_hrdata, fp_m1_hrdata;
  logic        fp_s_hsel, fp_s_hwrite, fp_s_hmastlock, fp_s_hready;
  logic [1:0]  fp_s_htrans;
  logic [2:0]  fp_s_hsize, fp_s_hburst;
  logic [3:0]  fp_s_hprot;
  logic [31:0] fp_s_haddr, fp_s_hwdata;

  int checks = 0;
  int failures = 0;

  ahb_arb_2m1s #(.ARB_MODE(0)) u_dut (
    .CLK(clk), .RES_N(res_n),
    .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize), .M0_HBURST(m0_hburst),
    .M0_HPROT(m0_hprot), .M0_HMASTLOCK(m0_hmastlock), .M0_HADDR(m0_haddr), .M0_HWDATA(m0_hwdata),
    .M0_HREADY(m0_hready), .M0_HRDATA(m0_hrdata), .M0_HRESP(m0_hresp),
    .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize), .M1_HBURST(m1_hburst),
    .M1_HPROT(m1_hprot), .M1_HMASTLOCK(m1_hmastlock), .M1_HADDR(m1_haddr), .M1_HWDATA(m1_hwdata),
    .M1_HREADY(m1_hready), .M1_HRDATA(m1_hrdata), .M1_HRESP(m1_hresp),
    .S_HSEL(s_hsel), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite), .S_HSIZE(s_hsize),
    .S_HBURST(s_hburst), .S_HPROT(s_hprot), .S_HMASTLOCK(s_hmastlock), .S_HADDR(s_haddr),
    .S_HWDATA(s_hwdata), .S_HREADY(s_hready), .S_HREADYOUT(s_hreadyout),
    .S_HRDATA(s_hrdata), .S_HRESP(s_hresp)
  );

  ahb_arb_2m1s #(.ARB_MODE(1)) u_dut_fp (
    .CLK(clk), .RES_N(res_n),
    .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize), .M0_HBURST(m0_hburst),
    .M0_HPROT(m0_hprot), .M0_HMASTLOCK(m0_hmastlock), .M0_HADDR(m0_haddr), .M0_HWDATA(m0_hwdata),
    .M0_HREADY(fp_m0_hready), .M0_HRDATA(fp_m0_hrdata), .M0_HRESP(fp_m0_hresp),
    .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize), .M1_HBURST(m1_hburst),
    .M1_HPROT(m1_hprot), .M1_HMASTLOCK(m1_hmastlock), .M1_HADDR(m1_haddr), .M1_HWDATA(m1_hwdata),
    .M1_HREADY(fp_m1_hready), .M1_HRDATA(fp_m1_hrdata), .M1_HRESP(fp_m1_hresp),
    .S_HSEL(fp_s_hsel), .S_HTRANS(fp_s_htrans), .S_HWRITE(fp_s_hwrite), .S_HSIZE(fp_s_hsize),
    .S_HBURST(fp_s_hburst), .S_HPROT(fp_s_hprot), .S_HMASTLOCK(fp_s_hmastlock), .S_HADDR(fp_s_haddr),
    .S_HWDATA(fp_s_hwdata), .S_HREADY(fp_s_hready), .S_HREADYOUT(1'b1),
    .S_HRDATA(32'h0), .S_HRESP(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory slave; address 0x3F0 answers with a two-cycle ERROR
  logic [31:0] mem [256];
  logic        dp_valid, dp_write, err_phase, dp_err;
  logic [31:0] dp_addr;

  assign dp_err      = dp_valid && (dp_addr == 32'h0000_03F0);
  assign s_hreadyout = !(dp_err && !err_phase);
  assign s_hresp     = dp_err;
  assign s_hrdata    = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'h0;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_addr   <= 32'h0;
      err_phase <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
    end else begin
      if (dp_valid && dp_write && s_hreadyout) mem[dp_addr[9:2]] <= s_hwdata;
      err_phase <= dp_err & ~err_phase;
      if (s_hready) begin
        dp_valid <= s_hsel & s_htrans[1];
        dp_addr  <= s_haddr;
        dp_write <= s_hwrite;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end else begin
      $display("check %s ok value=%h", tag, obs);
    end
  endtask

  task automatic set_m0(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock, input logic [3:0] prot);
    m0_htrans = tr; m0_hwrite = wr; m0_haddr = addr; m0_hwdata = wdata;
    m0_hmastlock = lock; m0_hprot = prot; m0_hsize = 3'b010; m0_hburst = 3'b000;
  endtask

  task automatic set_m1(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic lock, input logic [3:0] prot);
    m1_htrans = tr; m1_hwrite = wr; m1_haddr = addr; m1_hwdata = wdata;
    m1_hmastlock = lock; m1_hprot = prot; m1_hsize = 3'b010; m1_hburst = 3'b000;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    set_m1(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    res_n = 1'b1;
  endtask

  initial begin
    do_reset();
    res_n = 1'b0;
    #2;
    check_val("rst_m0_hready", 32'(m0_hready), 32'd1);
    check_val("rst_m1_hready", 32'(m1_hready), 32'd1);
    check_val("rst_m0_hrdata", m0_hrdata, 32'h0);
    check_val("rst_m0_hresp", 32'(m0_hresp), 32'd0);
    check_val("rst_s_htrans", 32'(s_htrans), 32'd0);
    check_val("rst_s_hsel", 32'(s_hsel), 32'd0);

    // Solo M0 write then read
    do_reset();
    set_m0(2'b10, 1'b1, 32'h10, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("solo_wr_addr", s_haddr, 32'h10);
    check_val("solo_wr_hready", 32'(m0_hready), 32'd1);
    next_cycle();
    set_m0(2'b10, 1'b0, 32'h10, 32'hA5A5_1234, 1'b0, 4'h3);
    #2;
    check_val("solo_wdata", s_hwdata, 32'hA5A5_1234);
    check_val("solo_rd_hready", 32'(m0_hready), 32'd1);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("solo_rdata", m0_hrdata, 32'hA5A5_1234);
    check_val("solo_m1_rdata", m1_hrdata, 32'h0);
    next_cycle();

    // Simultaneous reads, round-robin
    do_reset();
    set_m0(2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 4'h3);
    set_m1(2'b10, 1'b0, 32'h80, 32'h0, 1'b0, 4'h1);
    #2;
    check_val("rr_first_addr", s_haddr, 32'h40);
    next_cycle();
    set_m0(2'b10, 1'b0, 32'h44, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("rr_m1_stall", 32'(m1_hready), 32'd0);
    check_val("rr_m1_addr", s_haddr, 32'h80);
    check_val("rr_m1_nonseq", 32'(s_htrans), 32'h2);
    check_val("rr_m0_rdata", m0_hrdata, 32'hC0DE_0010);
    next_cycle();
    set_m1(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h1);
    #2;
    check_val("rr_m1_ready", 32'(m1_hready), 32'd1);
    check_val("rr_m1_rdata", m1_hrdata, 32'hC0DE_0020);
    check_val("rr_m0_stall", 32'(m0_hready), 32'd0);
    check_val("rr_m0_held_addr", s_haddr, 32'h44);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("rr_m0_rdata2", m0_hrdata, 32'hC0DE_0011);
    next_cycle();

    // Fixed priority: M0 always wins while requesting
    do_reset();
    set_m0(2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 4'h3);
    set_m1(2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 4'h1);
    #2;
    check_val("fp_c1_addr", fp_s_haddr, 32'h200);
    next_cycle();
    set_m0(2'b10, 1'b0, 32'h204, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("fp_c2_addr", fp_s_haddr, 32'h204);
    check_val("fp_c2_m1_stall", 32'(fp_m1_hready), 32'd0);
    next_cycle();
    set_m0(2'b10, 1'b0, 32'h208, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("fp_c3_addr", fp_s_haddr, 32'h208);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("fp_c4_m1_addr", fp_s_haddr, 32'h300);
    check_val("fp_c4_nonseq", 32'(fp_s_htrans), 32'h2);
    next_cycle();
    set_m0(2'b10, 1'b0, 32'h20C, 32'h0, 1'b0, 4'h3);
    set_m1(2'b10, 1'b0, 32'h304, 32'h0, 1'b0, 4'h1);
    #2;
    check_val("fp_c5_addr", fp_s_haddr, 32'h20C);
    check_val("fp_c5_m1_ready", 32'(fp_m1_hready), 32'd1);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("fp_c6_m1_addr", fp_s_haddr, 32'h304);
    next_cycle();

    // Locked read-modify-write by M1 at 0x100, M0 write contends
    do_reset();
    set_m1(2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 4'h1);
    #2;
    check_val("lock_rd_lock", 32'(s_hmastlock), 32'd1);
    next_cycle();
    set_m1(2'b10, 1'b1, 32'h100, 32'h0, 1'b1, 4'h1);
    set_m0(2'b10, 1'b1, 32'h100, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("lock_keep_prot", 32'(s_hprot), 32'h1);
    check_val("lock_m1_rdata", m1_hrdata, 32'hC0DE_0040);
    next_cycle();
    set_m1(2'b00, 1'b0, 32'h0, 32'hDEAD_0001, 1'b0, 4'h1);
    set_m0(2'b10, 1'b1, 32'h100, 32'h0000_00FF, 1'b0, 4'h3);
    #2;
    check_val("lock_m0_stall", 32'(m0_hready), 32'd0);
    check_val("lock_m1_wdata", s_hwdata, 32'hDEAD_0001);
    check_val("lock_m0_prot", 32'(s_hprot), 32'h3);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0000_00FF, 1'b0, 4'h3);
    #2;
    check_val("lock_m0_wdata", s_hwdata, 32'h0000_00FF);
    next_cycle();
    set_m0(2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 4'h3);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("lock_final_rdata", m0_hrdata, 32'h0000_00FF);
    next_cycle();

    // ERROR on M1's held transfer
    do_reset();
    set_m0(2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 4'h3);
    set_m1(2'b10, 1'b0, 32'h3F0, 32'h0, 1'b0, 4'h1);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("err_held_addr", s_haddr, 32'h3F0);
    next_cycle();
    set_m1(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h1);
    #2;
    check_val("err1_m1_hresp", 32'(m1_hresp), 32'd1);
    check_val("err1_m1_hready", 32'(m1_hready), 32'd0);
    check_val("err1_m0_hresp", 32'(m0_hresp), 32'd0);
    next_cycle();
    #2;
    check_val("err2_m1_hresp", 32'(m1_hresp), 32'd1);
    check_val("err2_m1_hready", 32'(m1_hready), 32'd1);
    check_val("err2_m0_hresp", 32'(m0_hresp), 32'd0);
    next_cycle();
    #2;
    check_val("err_done_hresp", 32'(m1_hresp), 32'd0);
    next_cycle();

    // Asynchronous reset while M1 waits
    do_reset();
    set_m0(2'b10, 1'b0, 32'h40, 32'h0, 1'b0, 4'h3);
    set_m1(2'b10, 1'b0, 32'h80, 32'h0, 1'b0, 4'h1);
    next_cycle();
    set_m0(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h3);
    #2;
    check_val("arst_m1_wait", 32'(m1_hready), 32'd0);
    res_n = 1'b0;
    #1;
    check_val("arst_pend1", 32'(u_dut.pend_q[1]), 32'd0);
    check_val("arst_m1_hready", 32'(m1_hready), 32'd1);
    check_val("arst_s_htrans", 32'(s_htrans), 32'd0);
    @(posedge clk);
    #1;
    set_m1(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 4'h1);
    res_n = 1'b1;
    #2;
    check_val("arst_no_replay1", 32'(s_htrans), 32'd0);
    next_cycle();
    #2;
    check_val("arst_no_replay2", 32'(s_htrans), 32'd0);
    check_val("arst_m1_idle", 32'(m1_hready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_arb_2m1s.md
Name: ahb_arb_2m1s

Overview:
Two-master to one-slave AHB-Lite arbiter placed directly upstream of the 128KB FPGA RAM slave port. M0 is the CPU data bus and M1 is the DMA engine. Uncontended transfers pass through combinationally with zero added wait states. A contending transfer is captured in a per-master hold register and the losing master is stalled through its HREADY until the slave completes that transfer.

Parameters:
ARB_MODE, 0, arbitration policy: 0 = round-robin (last-granted master loses a tie), 1 = fixed priority with M0 highest.

Ports:
CLK  input  1  system clock
RES_N  input  1  asynchronous active-low reset
Mx_HTRANS  input  2  master x transfer type (x = 0, 1; every Mx port exists for both masters)
Mx_HWRITE  input  1  master x write
Mx_HSIZE  input  3  master x size
Mx_HBURST  input  3  master x burst
Mx_HPROT  input  4  master x protection
Mx_HMASTLOCK  input  1  master x lock
Mx_HADDR  input  32  master x address
Mx_HWDATA  input  32  master x write data
Mx_HREADY  output  1  master x ready
Mx_HRDATA  output  32  master x read data
Mx_HRESP  output  1  master x response
S_HSEL  output  1  slave select
S_HTRANS  output  2  slave transfer type
S_HWRITE  output  1  slave write
S_HSIZE  output  3  slave size
S_HBURST  output  3  slave burst
S_HPROT  output  4  slave protection
S_HMASTLOCK  output  1  slave lock
S_HADDR  output  32  slave address
S_HWDATA  output  32  slave write data
S_HREADY  output  1  slave HREADY input; equals S_HREADYOUT (single-slave bus)
S_HREADYOUT  input  1  slave ready
S_HRDATA  input  32  slave read data
S_HRESP  input  1  slave response

Behaviour:
- Clock and reset: one clock, CLK. Reset RES_N is asynchronous and active-low.
- Reset values: both per-master FSMs in M_IDLE; pend_x=0; data_valid=0; last_grant=M1, so M0 wins the first tie. Outputs at reset: Mx_HREADY=1, Mx_HRESP=0, Mx_HRDATA=0, S_HTRANS=IDLE, S_HSEL=0.
- Per-master FSM states:
  - M_IDLE: no transfer outstanding. Mx_HREADY=1.
  - M_WAIT: the transfer is held in the hold register and not yet granted. Mx_HREADY=0.
  - M_DATA: the transfer is in its data phase at the slave. Mx_HREADY=S_HREADYOUT.
- Request: req_x = pend_x | (Mx_HREADY & Mx_HTRANS[1]).
- Arbitration:
  - Evaluated every cycle. The result is committed at an edge where S_HREADYOUT=1.
  - Lock override: if the previous granted address had HMASTLOCK=1 and that master still presents HMASTLOCK=1 with a request, it keeps the grant.
  - Otherwise the winner is decided by ARB_MODE.
- Slave address mux:
  - Winner with pend_x=1: drive the held fields, with S_HTRANS forced to NONSEQ.
  - Winner with pend_x=0: pass the live master signals through unchanged.
  - No request: S_HTRANS=IDLE.
  - S_HSEL=S_HTRANS[1].
- Hold capture: at an edge where Mx_HREADY=1 and Mx_HTRANS[1]=1 but master x is not committed as winner, latch HADDR, HWRITE, HSIZE, HBURST, HPROT and HMASTLOCK, set pend_x=1, and go to M_WAIT.
- Pending clear: pend_x clears at the edge where the held transfer is committed. The FSM then moves M_WAIT→M_DATA.
- Commit bookkeeping: at a commit edge, data_owner←winner, data_valid←1 and last_grant←winner. With no request, data_valid←0.
- Leaving M_DATA: when S_HREADYOUT=1, M_DATA→M_IDLE, or →M_DATA if master x's next transfer is committed at the same edge.
- Write data: master x holds HWDATA while its HREADY=0, so no write data is buffered. S_HWDATA = data_owner's HWDATA.
- Read data and response:
  - Mx_HRDATA = S_HRDATA when data_valid & data_owner==x, else 0.
  - Mx_HRESP = S_HRESP under the same condition, else 0.
  - The two-cycle ERROR response is passed through unchanged.
- Latency: uncontended transfers add 0 cycles. A losing transfer adds at least 1 cycle, plus the winner's data-phase length.
- Simultaneous new requests in ARB_MODE=0: the master ≠ last_grant wins.
- IDLE/BUSY transfers from a master are never held.
- Reset mid-transfer: all outstanding and held transfers are discarded and outputs return to reset values asynchronously.

Test Plan:
- Solo M0 write then read at 0x0000_0010, with 32'hA5A5_1234 written: zero added wait states (M0_HREADY never low with a zero-wait slave), and the read returns 32'hA5A5_1234.
- M0 and M1 both issue NONSEQ reads in the same cycle in ARB_MODE=0 after reset: M0 goes to the slave first. M1_HREADY is low for exactly 1 cycle. The slave then sees M1_HADDR as NONSEQ. The next simultaneous pair is granted to M1 first.
- ARB_MODE=1 with M1 issuing back-to-back and M0 requesting continuously: M0 always wins. M1 is granted only in cycles where M0 presents IDLE.
- Lock: M1 runs a locked read-modify-write (HMASTLOCK=1) to 0x100 while M0 requests mid-sequence: M0 is held until M1 drops HMASTLOCK. M0's held write of 32'h0000_00FF then lands after M1's write.
- Slave ERROR on M1's held transfer: M1_HRESP=1 for 2 cycles (M1_HREADY 0 then 1) and M0_HRESP stays 0.
- RES_N asserted while M1 is in M_WAIT: on the same edge pend_1=0, M1_HREADY=1 and S_HTRANS=IDLE. After release, no held transfer is replayed.
